apb_master_mc: RTL

Parametrised, multi-slave APB (AMBA 3) master, the next generation of the team's 2-slave APB master. It accepts read/write commands over a valid/ready command port and runs one APB SETUP/ACCESS transfer per command. It decodes the target slave from the upper address bits, honours per-slave PREADY and PSLVERR, and returns the result on a one-cycle response port. It sits between an internal bus client (CPU bridge or test sequencer) and up to NUM_SLAVES APB peripherals.

---
 rtl/apb_master_mc.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/apb_master_mc.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_mc
//  Purpose  : Multi-slave APB3 master. One SETUP/ACCESS transfer per accepted
//             command, slave decoded from the upper address bits.
//             Optional ACCESS timeout: define APB_MASTER_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module apb_master_mc #(
   parameter int ADDR_WIDTH     = 9,
   parameter int DATA_WIDTH     = 8,
   parameter int NUM_SLAVES     = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                             PCLK,
   input  logic                             PRESETn,
   input  logic                             cmd_valid,
   output logic                             cmd_ready,
   input  logic                             cmd_write,
   input  logic [ADDR_WIDTH-1:0]            cmd_addr,
   input  logic [DATA_WIDTH-1:0]            cmd_wdata,
   output logic                             rsp_valid,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic                             rsp_err,
   output logic [NUM_SLAVES-1:0]            PSEL,
   output logic                             PENABLE,
   output logic [ADDR_WIDTH-1:0]            PADDR,
   output logic                             PWRITE,
   output logic [DATA_WIDTH-1:0]            PWDATA,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
   input  logic [NUM_SLAVES-1:0]            PREADY,
   input  logic [NUM_SLAVES-1:0]            PSLVERR
);

   localparam int c_SEL_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 0;
   // One spare bit so the index can represent NUM_SLAVES for the range check
   localparam int c_IDX_W    = c_SEL_BITS + 1;
   localparam logic [c_IDX_W-1:0] c_NUM_SLV = c_IDX_W'(NUM_SLAVES);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_DECERR = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [NUM_SLAVES-1:0] r_sel;
   logic [NUM_SLAVES-1:0] w_cmd_sel;
   logic [c_IDX_W-1:0]    w_cmd_idx;
   logic                  w_dec_err;
   logic                  w_accept;
   logic                  w_pready;
   logic                  w_pslverr;
   logic [DATA_WIDTH-1:0] w_prdata;
   logic                  w_timeout;

   if (c_SEL_BITS > 0) begin : g_idx_dec
      assign w_cmd_idx = {1'b0, cmd_addr[ADDR_WIDTH-1 -: c_SEL_BITS]};
   end else begin : g_idx_single
      assign w_cmd_idx = '0;
   end

   assign w_dec_err = (w_cmd_idx >= c_NUM_SLV);

   always_comb begin
      w_cmd_sel = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         w_cmd_sel[i] = (w_cmd_idx == c_IDX_W'(i));
      end
   end

   // The one-hot select masks out every unselected slave's response signals
   assign w_pready  = |(PREADY  & r_sel);
   assign w_pslverr = |(PSLVERR & r_sel);

   always_comb begin
      w_prdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         w_prdata = w_prdata | (PRDATA[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_sel[i]}});
      end
   end

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [c_CNT_W-1:0] r_wait_cnt;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_wait_cnt <= '0;
      end else if (r_state != S_ACCESS) begin
         r_wait_cnt <= '0;
      end else if (!w_pready) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   // Fires on the wait cycle that brings the count to the limit
   assign w_timeout = (r_state == S_ACCESS) && !w_pready &&
                      (r_wait_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      cmd_ready   = 1'b0;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               w_state_nxt = w_dec_err ? S_DECERR : S_SETUP;
            end
         end
         S_SETUP: begin
            w_state_nxt = S_ACCESS;
         end
         S_ACCESS: begin
            if (w_timeout) begin
               w_state_nxt = S_IDLE;
            end else if (w_pready) begin
               cmd_ready = 1'b1;
               if (cmd_valid) begin
                  w_state_nxt = w_dec_err ? S_DECERR : S_SETUP;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_accept = cmd_valid & cmd_ready;
   assign PSEL     = ((r_state == S_SETUP) || (r_state == S_ACCESS)) ? r_sel : '0;
   assign PENABLE  = (r_state == S_ACCESS);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         PADDR     <= '0;
         PWRITE    <= 1'b0;
         PWDATA    <= '0;
         r_sel     <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         if (w_accept) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PWDATA <= cmd_write ? cmd_wdata : '0;
            r_sel  <= w_cmd_sel;
         end
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         if ((r_state == S_ACCESS) && w_pready) begin
            rsp_valid <= 1'b1;
            rsp_err   <= w_pslverr;
            rsp_rdata <= (!PWRITE && !w_pslverr) ? w_prdata : '0;
         end else if (w_timeout || (r_state == S_DECERR)) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
